// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter among REQ_ byte-stream requesters. The
// arbiter picks one requester in round-robin order and locks the grant to it
// for the whole packet, so bytes from different packets never interleave on
// the tx side. While a packet is in progress the owner's valid/data/ready are
// passed straight through with zero latency.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   When defined, an owner that stops presenting bytes for TIMEOUT_ cycles
//   loses the grant and a one-cycle abort pulse is produced. When undefined,
//   no stall counter exists and abort is tied low.
//
// Parameters:
//   REQ_      number of requesters (2..8)
//   DATA_     byte width
//   TIMEOUT_  stall limit in cycles (>= 2), timeout build only
//
// Ports:
//   clk        clock
//   rst_       synchronous active-high reset
//   req_valid  per-requester byte valid
//   req_data   requester i byte at [i*DATA_ +: DATA_]
//   req_last   byte is the last one of its packet
//   req_ready  byte accepted (only ever set for the owner)
//   tx_valid   byte valid toward the UART TX buffer
//   tx_data    byte toward the UART (0 when tx_valid is low)
//   tx_ready   UART TX buffer can take a byte
//   grant      one-hot owner, all-zero when idle
//   busy       a packet is in progress
//   abort      one-cycle pulse when a stalled packet is dropped
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int REQ_     = 4,
    parameter int DATA_    = 8,
    parameter int TIMEOUT_ = 1024
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [REQ_-1:0]       req_valid,
    input  logic [REQ_*DATA_-1:0] req_data,
    input  logic [REQ_-1:0]       req_last,
    output logic [REQ_-1:0]       req_ready,
    output logic                  tx_valid,
    output logic [DATA_-1:0]      tx_data,
    input  logic                  tx_ready,
    output logic [REQ_-1:0]       grant,
    output logic                  busy,
    output logic                  abort
);

    localparam int PTR_W = (REQ_ > 1) ? $clog2(REQ_) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [PTR_W-1:0]  g_reg, g_next;
    logic [REQ_-1:0]   grant_reg, grant_next;

    // Unpacked view of the flat request data bus.
    logic [DATA_-1:0]  req_bytes [REQ_];

    // Round-robin selection signals.
    logic [REQ_-1:0]   hi_mask;      // requesters at index >= ptr
    logic [REQ_-1:0]   hi_req;
    logic [REQ_-1:0]   hi_first;     // lowest requester at or above ptr
    logic [REQ_-1:0]   lo_first;     // lowest requester overall (wrap case)
    logic [REQ_-1:0]   pick_onehot;
    logic [PTR_W-1:0]  pick_idx;
    logic [REQ_-1:0]   idx_col [PTR_W];

    logic              owner_valid;
    logic              owner_last;
    logic              handshake;
    logic [PTR_W-1:0]  g_inc;

    assign owner_valid = req_valid[g_reg];
    assign owner_last  = req_last[g_reg];
    assign g_inc       = (g_reg == PTR_W'(REQ_ - 1)) ? '0 : g_reg + PTR_W'(1);

    // -----------------------------------------------------------------------
    // Per-requester slices: data unpacking, ready fan-out and the round-robin
    // "first set bit" search. Searching the requesters at or above ptr first
    // and falling back to the lowest requester overall gives the wrap-around
    // order ptr, ptr+1, ..., REQ_-1, 0, ..., ptr-1 without a rotator.
    // -----------------------------------------------------------------------
    genvar gi;
    genvar gb;
    generate
        for (gi = 0; gi < REQ_; gi++) begin : g_req
            localparam logic [REQ_-1:0] BELOW = REQ_'((1 << gi) - 1);

            assign req_bytes[gi] = req_data[gi*DATA_ +: DATA_];
            assign req_ready[gi] = (state_reg == XFER) && (g_reg == PTR_W'(gi)) && tx_ready;

            assign hi_mask[gi]  = (PTR_W'(gi) >= ptr_reg);
            assign hi_first[gi] = hi_req[gi] & ~(|(hi_req & BELOW));
            assign lo_first[gi] = req_valid[gi] & ~(|(req_valid & BELOW));

            // Binary encode the one-hot pick: column gb collects the requesters
            // whose index has bit gb set.
            for (gb = 0; gb < PTR_W; gb++) begin : g_bit
                if (((gi >> gb) & 1) == 1) begin : g_set
                    assign idx_col[gb][gi] = pick_onehot[gi];
                end else begin : g_clr
                    assign idx_col[gb][gi] = 1'b0;
                end
            end
        end

        for (gb = 0; gb < PTR_W; gb++) begin : g_enc
            assign pick_idx[gb] = |idx_col[gb];
        end
    endgenerate

    assign hi_req      = req_valid & hi_mask;
    assign pick_onehot = (|hi_req) ? hi_first : lo_first;

    assign handshake   = (state_reg == XFER) && owner_valid && tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_ > 2) ? $clog2(TIMEOUT_) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_ - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             abort_reg, abort_next;
`endif

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        g_next     = g_reg;
        grant_next = grant_reg;
        tx_valid   = 1'b0;
        tx_data    = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_next   = cnt_reg;
        abort_next = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                cnt_next = '0;
`endif
                if (|req_valid) begin
                    state_next = XFER;
                    g_next     = pick_idx;
                    grant_next = pick_onehot;
                end
            end

            XFER: begin
                tx_valid = owner_valid;
                tx_data  = owner_valid ? req_bytes[g_reg] : '0;

                if (handshake) begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_next = '0;
`endif
                    if (owner_last) begin
                        state_next = IDLE;
                        ptr_next   = g_inc;
                        grant_next = '0;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only an absent owner counts as a stall; a busy UART
                // (tx_ready low with a byte pending) never times out.
                else if (!owner_valid) begin
                    if (cnt_reg == CNT_MAX) begin
                        state_next = IDLE;
                        ptr_next   = g_inc;
                        grant_next = '0;
                        abort_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
`endif
            end

            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. A reset in the middle of a packet just drops it; no
    // abort pulse is produced.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            g_reg     <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            g_reg     <= g_next;
            grant_reg <= grant_next;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst_) begin
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            abort_reg <= abort_next;
        end
    end

    assign abort = abort_reg;
`else
    assign abort = 1'b0;
`endif

    assign grant = grant_reg;
    assign busy  = (state_reg == XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (REQ_=4, DATA_=8, TIMEOUT_=8). Each
// requester is a small byte FIFO that presents its head byte and pops on
// req_valid & req_ready. Expected tx bytes (owner, data) are queued in
// hand-computed order; an independent monitor pops and compares on every tx
// handshake. Cycle-exact checks on grant/busy/abort are made from the
// stimulus process.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .REQ_    (4),
        .DATA_   (8),
        .TIMEOUT_(8)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .grant    (grant),
        .busy     (busy),
        .abort    (abort)
    );

    // Requester byte FIFOs: {last, data}
    logic [8:0] mem [4][64];
    int         wr [4];
    int         rd [4];

    // Scoreboard of expected tx handshakes: {owner[1:0], data[7:0]}
    logic [9:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rd[i] < wr[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = mem[i][rd[i]][7:0];
                req_last[i]        = mem[i][rd[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic enqueue(input int r, input logic [7:0] d, input logic l);
        mem[r][wr[r]] = {l, d};
        wr[r]++;
        drive();
    endtask

    task automatic push(input int o, input logic [7:0] d);
        logic [1:0] ob;
        ob = o[1:0];
        exp_q.push_back({ob, d});
    endtask

    // One clock cycle: capture requester handshakes mid-cycle, then after the
    // edge pop accepted bytes and present the next ones. Returns at posedge+2.
    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (hs[i]) rd[i]++;
        drive();
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_q.size() + int'(busy), 0);
    endtask

    // Monitor: every tx handshake must match the head of the scoreboard.
    initial begin : monitor
        logic [9:0] e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (busy)
                chk("req_ready_mirror", {28'd0, req_ready}, {28'd0, grant & {4{tx_ready}}});
            if (tx_valid && tx_ready) begin
                $display("tx grant=%b data=0x%02h", grant, tx_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got grant=%b data=0x%02h, expected no byte", grant, tx_data);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e[9:8];
                    chk("tx_byte", {20'd0, grant, tx_data}, {20'd0, oh, e[7:0]});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] pat;
        logic [3:0] oh;
        logic       b;
        int         own;

        for (int i = 0; i < 4; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
        tx_ready = 1'b1;
        drive();

        // ---------------- reset values ----------------
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'hA0 + 8'(i);
            enqueue(i, d, 1'b1);
            push(i, d);
        end
        repeat (3) begin
            tick();
            chk("reset_outputs", {21'd0, grant, busy, abort, tx_valid, req_ready}, 32'd0);
        end
        rst_ = 1'b0;
        tick();
        chk("first_grant", {28'd0, grant}, 32'h1);
        drain();

        // ---------------- single packet ----------------
        enqueue(2, 8'h41, 1'b0);
        enqueue(2, 8'h42, 1'b0);
        enqueue(2, 8'h43, 1'b1);
        push(2, 8'h41);
        push(2, 8'h42);
        push(2, 8'h43);
        for (int t = 0; t < 3; t++) begin
            logic [7:0] d;
            d = 8'h41 + 8'(t);
            tick();
            chk("single_data", {19'd0, grant, tx_valid, tx_data}, {19'd0, 4'b0100, 1'b1, d});
        end
        tick();
        chk("single_busy_fall", {31'd0, busy}, 32'd0);
        drain();

        // ---------------- round-robin fairness ----------------
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;
        enqueue(0, 8'h00, 1'b0); enqueue(0, 8'h01, 1'b1);
        enqueue(0, 8'h02, 1'b0); enqueue(0, 8'h03, 1'b1);
        enqueue(1, 8'h10, 1'b0); enqueue(1, 8'h11, 1'b1);
        enqueue(2, 8'h20, 1'b0); enqueue(2, 8'h21, 1'b1);
        enqueue(3, 8'h30, 1'b0); enqueue(3, 8'h31, 1'b1);
        push(0, 8'h00); push(0, 8'h01);
        push(1, 8'h10); push(1, 8'h11);
        push(2, 8'h20); push(2, 8'h21);
        push(3, 8'h30); push(3, 8'h31);
        push(0, 8'h02); push(0, 8'h03);
        // Each packet: two transfer cycles followed by one idle cycle.
        for (int t = 1; t <= 15; t++) begin
            tick();
            b   = ((t % 3) != 0);
            own = ((t - 1) / 3) % 4;
            oh  = b ? (4'b0001 << own) : 4'b0000;
            chk("rr_slot", {27'd0, b ? busy : busy, grant}, {27'd0, b, oh});
        end
        drain();

        // ---------------- backpressure ----------------
        enqueue(1, 8'h10, 1'b0);
        enqueue(1, 8'h11, 1'b1);
        push(1, 8'h10);
        push(1, 8'h11);
        pat = 4'b1001;  // bit t = tx_ready in transfer cycle t
        for (int t = 0; t < 4; t++) begin
            tick();
            tx_ready = pat[t];
            #1;
            chk("bp_ready", {24'd0, grant, req_ready}, {24'd0, 4'b0010, pat[t] ? 4'b0010 : 4'b0000});
        end
        tx_ready = 1'b1;
        tick();
        chk("bp_busy_fall", {31'd0, busy}, 32'd0);

        enqueue(2, 8'h77, 1'b1);
        push(2, 8'h77);
        tx_ready = 1'b0;
        repeat (12) begin
            tick();
            chk("stall_hold", {26'd0, abort, grant, tx_valid}, {26'd0, 1'b0, 4'b0100, 1'b1});
        end
        tx_ready = 1'b1;
        drain();

        // ---------------- timeout ----------------
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;
        enqueue(0, 8'h55, 1'b0);
        enqueue(3, 8'h66, 1'b1);
        push(0, 8'h55);
`ifdef UART_ARB_TIMEOUT_EN
        push(3, 8'h66);
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("to_abort", {31'd0, abort}, (t == 10) ? 32'd1 : 32'd0);
            if (t == 11)
                chk("to_regrant", {28'd0, grant}, 32'h8);
        end
`else
        repeat (100) begin
            tick();
            chk("no_to_hold", {27'd0, abort, grant}, {27'd0, 1'b0, 4'b0001});
        end
        enqueue(0, 8'h56, 1'b1);
        push(0, 8'h56);
        push(3, 8'h66);
`endif
        drain();

        // ---------------- reset mid-packet ----------------
        for (int k = 0; k < 5; k++)
            enqueue(1, 8'h81 + 8'(k), (k == 4));
        push(1, 8'h81);
        push(1, 8'h82);
        tick();
        chk("mid_grant", {28'd0, grant}, 32'h2);
        tick();
        rst_ = 1'b1;
        enqueue(0, 8'h90, 1'b1);
        tick();
        chk("mid_reset", {25'd0, grant, busy, abort, tx_valid}, 32'd0);
        rst_ = 1'b0;
        push(0, 8'h90);
        push(1, 8'h83);
        push(1, 8'h84);
        push(1, 8'h85);
        tick();
        chk("mid_rearb", {28'd0, grant}, 32'h1);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
